// File: rtl/vga_image_rom_if.sv
// Pixel-address request and colour response bundle between the VGA address
// generator/colour mux (master) and the image ROM (slave).
interface vga_image_rom_if #(
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned INDEX_WIDTH = 8,
    parameter int unsigned COLOR_WIDTH = 24
);
    logic [ADDR_WIDTH-1:0]  address;
    logic                   addr_valid;
    logic                   splash_sel;
    logic [INDEX_WIDTH-1:0] index_main;
    logic [INDEX_WIDTH-1:0] index_splash;
    logic [COLOR_WIDTH-1:0] bgr_main;
    logic [COLOR_WIDTH-1:0] bgr_splash;
    logic [COLOR_WIDTH-1:0] colour_out;
    logic                   data_valid;

    modport master (
        output address, addr_valid, splash_sel,
        input  index_main, index_splash, bgr_main, bgr_splash, colour_out, data_valid
    );

    modport slave (
        input  address, addr_valid, splash_sel,
        output index_main, index_splash, bgr_main, bgr_splash, colour_out, data_valid
    );
endinterface

// File: rtl/vga_image_rom.sv
// Two-stage image store: pixel address -> palette index (main/splash) -> BGR colour.
// ROM images are the generated pattern: main = low address byte, splash = its inverse, palette = {i, ~i, i}.
module vga_image_rom #(
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned DEPTH       = 307200,
    parameter int unsigned INDEX_WIDTH = 8,
    parameter int unsigned COLOR_WIDTH = 24
) (
    input  logic          clock,
    input  logic          reset,
    vga_image_rom_if.slave bus
);

    // Addresses past the frame read 0 rather than aliasing into the table.
    function automatic logic [INDEX_WIDTH-1:0] main_rom(input logic [ADDR_WIDTH-1:0] a);
        main_rom = '0;
        if (32'(a) < DEPTH) main_rom = a[INDEX_WIDTH-1:0];
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] splash_rom(input logic [ADDR_WIDTH-1:0] a);
        splash_rom = '0;
        if (32'(a) < DEPTH) splash_rom = ~a[INDEX_WIDTH-1:0];
    endfunction

    function automatic logic [COLOR_WIDTH-1:0] palette_rom(input logic [INDEX_WIDTH-1:0] i);
        palette_rom = COLOR_WIDTH'({i, ~i, i});
    endfunction

    logic [INDEX_WIDTH-1:0] index_main_q,   index_main_d;
    logic [INDEX_WIDTH-1:0] index_splash_q, index_splash_d;
    logic                   valid1_q,       valid1_d;
    logic                   sel1_q,         sel1_d;
    logic [COLOR_WIDTH-1:0] bgr_main_q,     bgr_main_d;
    logic [COLOR_WIDTH-1:0] bgr_splash_q,   bgr_splash_d;
    logic                   valid2_q,       valid2_d;
    logic                   sel2_q,         sel2_d;

    // Free-running pipeline: every slot advances each cycle, valid only rides along.
    always_comb begin
        index_main_d   = main_rom(bus.address);
        index_splash_d = splash_rom(bus.address);
        valid1_d       = bus.addr_valid;
        sel1_d         = bus.splash_sel;
        bgr_main_d     = palette_rom(index_main_q);
        bgr_splash_d   = palette_rom(index_splash_q);
        valid2_d       = valid1_q;
        sel2_d         = sel1_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index_main_q   <= '0;
            index_splash_q <= '0;
            valid1_q       <= 1'b0;
            sel1_q         <= 1'b0;
            bgr_main_q     <= '0;
            bgr_splash_q   <= '0;
            valid2_q       <= 1'b0;
            sel2_q         <= 1'b0;
        end else begin
            index_main_q   <= index_main_d;
            index_splash_q <= index_splash_d;
            valid1_q       <= valid1_d;
            sel1_q         <= sel1_d;
            bgr_main_q     <= bgr_main_d;
            bgr_splash_q   <= bgr_splash_d;
            valid2_q       <= valid2_d;
            sel2_q         <= sel2_d;
        end
    end

    assign bus.index_main   = index_main_q;
    assign bus.index_splash = index_splash_q;
    assign bus.bgr_main     = bgr_main_q;
    assign bus.bgr_splash   = bgr_splash_q;
    assign bus.data_valid   = valid2_q;
    // Select travels with its pixel, so the mux uses the stage-2 copy.
    assign bus.colour_out   = sel2_q ? bgr_splash_q : bgr_main_q;

endmodule

// File: tb/tb_vga_image_rom.sv
// Randomised bench for vga_image_rom against a history-based reference model.
module tb_vga_image_rom;

    localparam int unsigned ADDR_WIDTH  = 19;
    localparam int unsigned DEPTH       = 307200;
    localparam int unsigned INDEX_WIDTH = 8;
    localparam int unsigned COLOR_WIDTH = 24;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    vga_image_rom_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH),
        .COLOR_WIDTH(COLOR_WIDTH)
    ) bus ();

    vga_image_rom #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .INDEX_WIDTH(INDEX_WIDTH),
        .COLOR_WIDTH(COLOR_WIDTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned a;
        bit          v;
        bit          s;
    } slot_t;

    // Inputs sampled at the most recent rising edges since reset, newest first.
    slot_t hist[$];

    function automatic int unsigned ref_main(input int unsigned a);
        return (a < DEPTH) ? (a % 256) : 0;
    endfunction

    function automatic int unsigned ref_splash(input int unsigned a);
        return (a < DEPTH) ? (255 - (a % 256)) : 0;
    endfunction

    function automatic int unsigned ref_pal(input int unsigned i);
        return (i * 65536) + ((255 - i) * 256) + i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_idx_m"}, 32'(bus.index_main), 32'd0);
        chk({tag, "_idx_s"}, 32'(bus.index_splash), 32'd0);
        chk({tag, "_bgr_m"}, 32'(bus.bgr_main), 32'd0);
        chk({tag, "_bgr_s"}, 32'(bus.bgr_splash), 32'd0);
        chk({tag, "_col"},   32'(bus.colour_out), 32'd0);
        chk({tag, "_dv"},    32'(bus.data_valid), 32'd0);
    endtask

    task automatic check_outputs();
        int unsigned im, is, pm, ps, bm, bs, col;
        bit dv, sel;
        im  = (hist.size() >= 1) ? ref_main(hist[0].a)   : 0;
        is  = (hist.size() >= 1) ? ref_splash(hist[0].a) : 0;
        pm  = (hist.size() >= 2) ? ref_main(hist[1].a)   : 0;
        ps  = (hist.size() >= 2) ? ref_splash(hist[1].a) : 0;
        dv  = (hist.size() >= 2) ? hist[1].v : 1'b0;
        sel = (hist.size() >= 2) ? hist[1].s : 1'b0;
        bm  = ref_pal(pm);
        bs  = ref_pal(ps);
        col = sel ? bs : bm;
        chk("idx_main",   32'(bus.index_main),   im);
        chk("idx_splash", 32'(bus.index_splash), is);
        chk("bgr_main",   32'(bus.bgr_main),     bm);
        chk("bgr_splash", 32'(bus.bgr_splash),   bs);
        chk("colour_out", 32'(bus.colour_out),   col);
        chk("data_valid", 32'(bus.data_valid),   32'(dv));
    endtask

    // Called at a falling edge; drives one pixel and checks after the next rise.
    task automatic cycle(input int unsigned a, input bit v, input bit s);
        slot_t e;
        bus.address    = ADDR_WIDTH'(a);
        bus.addr_valid = v;
        bus.splash_sel = s;
        @(posedge clock);
        e.a = a;
        e.v = v;
        e.s = s;
        hist.push_front(e);
        if (hist.size() > 2) void'(hist.pop_back());
        @(negedge clock);
        check_outputs();
    endtask

    // Asynchronous reset asserted between edges; released at a falling edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_zero(tag);
        @(posedge clock);
        @(negedge clock);
        check_zero({tag, "_held"});
        reset = 1'b0;
        hist.delete();
    endtask

    initial begin
        int unsigned a;
        int unsigned r;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.address    = '0;
        bus.addr_valid = 1'b0;
        bus.splash_sel = 1'b0;
        #1;
        check_zero("por");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        hist.delete();

        // Single pixel, main then splash selection.
        cycle(32'h5, 1'b1, 1'b0);
        chk("tp_idx_m", 32'(bus.index_main), 32'h05);
        chk("tp_idx_s", 32'(bus.index_splash), 32'hFA);
        cycle(32'h5, 1'b1, 1'b1);
        chk("tp_bgr_m", 32'(bus.bgr_main), 32'h05FA05);
        chk("tp_col_m", 32'(bus.colour_out), 32'h05FA05);
        chk("tp_dv",    32'(bus.data_valid), 32'd1);
        cycle(32'h5, 1'b1, 1'b0);
        chk("tp_col_s", 32'(bus.colour_out), 32'hFA05FA);

        // Streaming with per-cycle select toggling.
        for (int i = 0; i < 4; i++) cycle(32'(i), 1'b1, 1'(i % 2));
        for (int i = 0; i < 2; i++) cycle(32'h10, 1'b1, 1'b0);

        // Frame boundary and top of the address space.
        cycle(DEPTH - 1, 1'b1, 1'b0);
        chk("bnd_last", 32'(bus.index_main), 32'hFF);
        cycle(DEPTH, 1'b1, 1'b0);
        chk("bnd_past_m", 32'(bus.index_main), 32'd0);
        chk("bnd_past_s", 32'(bus.index_splash), 32'd0);
        cycle(32'h7FFFF, 1'b1, 1'b1);
        cycle(32'h7FFFF, 1'b1, 1'b0);
        chk("bnd_top_bgr", 32'(bus.bgr_main), 32'h00FF00);

        // Valid pulse pattern, then mid-stream reset and recovery.
        cycle(32'd20, 1'b1, 1'b0);
        cycle(32'd21, 1'b0, 1'b0);
        cycle(32'd22, 1'b1, 1'b0);
        cycle(32'd23, 1'b0, 1'b0);
        cycle(32'd24, 1'b0, 1'b0);
        do_reset("mid");
        cycle(32'd100, 1'b1, 1'b1);
        chk("rel_dv1", 32'(bus.data_valid), 32'd0);
        cycle(32'd101, 1'b1, 1'b0);
        chk("rel_dv2", 32'(bus.data_valid), 32'd1);

        // Random traffic biased toward the frame boundary, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = $urandom_range(0, 524287);
            else if (r < 8) a = $urandom_range(DEPTH - 8, DEPTH + 8);
            else            a = $urandom_range(524280, 524287);
            cycle(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) do_reset("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_image_rom.md
Name: vga_image_rom

Overview:
- Read-only image store for the VGA display path: two frame-index ROMs (main screen, splash screen), each holding one 8-bit palette index per 640x480 pixel, plus a shared 256-entry palette ROM mapping index to 24-bit BGR colour.
- Sits between the VGA address generator (linear pixel address) and the colour mux of the VGA controller.
- Produces both screens' colours every cycle plus a screen-selected colour, all through a fixed 2-cycle pipeline.

Parameters:
- ADDR_WIDTH, 19, pixel address width.
- DEPTH, 307200, frame-index ROM entries (640*480).
- INDEX_WIDTH, 8, palette index width; palette depth = 2**INDEX_WIDTH.
- COLOR_WIDTH, 24, colour width, packed {B[23:16], G[15:8], R[7:0]}.
- MAIN_INIT_FILE, "img_data.mif", init contents of main index ROM.
- SPLASH_INIT_FILE, "splash_data.mif", init contents of splash index ROM.
- PALETTE_INIT_FILE, "img_index.mif", init contents of palette ROM.

Ports:
- clock  in  1  single system/pixel clock, all registers on rising edge.
- reset  in  1  asynchronous, active-high; clears pipeline registers.
- address  in  ADDR_WIDTH  linear pixel address (y*640+x).
- addr_valid  in  1  address qualifier (blank_n).
- splash_sel  in  1  1 = select splash colour on colour_out, 0 = main.
- index_main  out  INDEX_WIDTH  main ROM palette index (stage 1).
- index_splash  out  INDEX_WIDTH  splash ROM palette index (stage 1).
- bgr_main  out  COLOR_WIDTH  palette colour for main index (stage 2).
- bgr_splash  out  COLOR_WIDTH  palette colour for splash index (stage 2).
- colour_out  out  COLOR_WIDTH  bgr_splash if delayed splash_sel=1 else bgr_main.
- data_valid  out  1  addr_valid delayed 2 cycles.

Behaviour:
- Stage 1 (edge N): index_main <= MAIN[address], index_splash <= SPLASH[address]; addr_valid and splash_sel captured alongside.
- Stage 2 (edge N+1): bgr_main <= PAL[index_main], bgr_splash <= PAL[index_splash]; data_valid, delayed splash_sel updated.
- Total latency address -> bgr/colour_out/data_valid: exactly 2 rising edges.
- Pipeline is free-running and advances every cycle regardless of addr_valid; addr_valid only propagates to data_valid.
- Out-of-range address (address >= DEPTH, i.e. 307200..524287): index outputs are 0; no wrap-around or aliasing into the table.
- Palette lookup always in range, since the index is 8 bits.
- colour_out is a combinational mux of stage-2 registers using the splash_sel captured in the same pipeline slot, so select stays aligned with its pixel.
- Reset (asserted at any time, asynchronous):
  - index_main, index_splash, bgr_main, bgr_splash, colour_out, data_valid, delayed select all go to 0 immediately.
  - ROM contents are unaffected.
  - After release, first valid data appears 2 edges after the first sampled address.
- ROM contents are loaded only at elaboration from the init files; there is no write port.
- Uninitialised entries read as 0.

Test Plan:
- Test init files (all benches): MAIN[a] = a[7:0], SPLASH[a] = ~a[7:0], PAL[i] = {i, i^8'hFF, i}.
- Reset then address=0x00005, addr_valid=1, splash_sel=0 -> after 1 edge index_main=0x05, index_splash=0xFA; after 2 edges bgr_main=0x05FA05, colour_out=0x05FA05, data_valid=1.
- Same address with splash_sel=1 -> after 2 edges colour_out=bgr_splash=0xFA05FA.
- Streaming: addresses 0,1,2,3 on consecutive cycles -> colour_out sequence 0x00FF00, 0x01FE01, 0x02FD02, 0x03FC03 starting at cycle 2, one per cycle, no gaps. Toggling splash_sel per cycle -> each output uses its own cycle's select.
- Boundary: address=307199 -> index_main=0xFF; address=307200 and 0x7FFFF -> index_main=0, index_splash=0, bgr_main=0x00FF00.
- Reset asserted mid-stream between edges -> all outputs 0 immediately without a clock edge. Release with addr_valid=1 -> data_valid rises on the 2nd edge after release.
- addr_valid pulse 1,0,1 -> data_valid reproduces 1,0,1 delayed by 2 cycles; bgr outputs still update every cycle.
